// File: rtl/instruction_loader.sv
// Length-prefixed byte-stream loader that fills the CPU instruction memory with big-endian words.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_address,
  output logic [31:0] instruction_initialize_data,
  output logic        instruction_write,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CSUM  = 3'd4,
`endif
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t      state;
  state_t      next_state;
  logic        rst_hold;
  logic [1:0]  byte_cnt;
  logic [15:0] count;
  logic [15:0] hdr_count;
  logic        accept;
  logic        go;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count[7:0], in_data};
  // rst_hold masks a start pulse that coincides with the reset release edge
  assign go        = start && !rst_hold &&
                     ((state == IDLE) || (state == DONE) || (state == ERROR));

  // Byte acceptance is a pure state decode, independent of in_valid
  always_comb begin
    in_ready = 1'b0;
    case (state)
      HDR:     in_ready = 1'b1;
      DATA:    in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CSUM:    in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  // Reset-release qualifier for start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_hold <= 1'b1;
    end else begin
      rst_hold <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (go) next_state = HDR;
        else    next_state = IDLE;
      end
      HDR: begin
        if (accept && (byte_cnt == 2'd1)) begin
          if (hdr_count == 16'd0)                          next_state = END_STATE;
          else if ({16'h0000, hdr_count} > MAX_WORDS)      next_state = ERROR;
          else                                             next_state = DATA;
        end else begin
          next_state = HDR;
        end
      end
      DATA: begin
        if (accept && (byte_cnt == 2'd3)) next_state = WRITE;
        else                              next_state = DATA;
      end
      WRITE: begin
        if (count == 16'd1) next_state = END_STATE;
        else                next_state = DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          if (in_data == csum) next_state = DONE;
          else                 next_state = ERROR;
        end else begin
          next_state = CSUM;
        end
      end
`endif
      DONE: begin
        if (go) next_state = HDR;
        else    next_state = DONE;
      end
      ERROR: begin
        if (go) next_state = HDR;
        else    next_state = ERROR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: header/word assembly, remaining count, write address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt                       <= 2'd0;
      count                          <= 16'd0;
      instruction_initialize_address <= BASE_ADDR;
      instruction_initialize_data    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum                           <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (go) begin
            byte_cnt                       <= 2'd0;
            count                          <= 16'd0;
            instruction_initialize_address <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum                           <= 8'd0;
`endif
          end
        end
        HDR: begin
          if (accept) begin
            byte_cnt <= (byte_cnt == 2'd1) ? 2'd0 : (byte_cnt + 2'd1);
            count    <= hdr_count;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum_update(csum, in_data);
`endif
          end
        end
        DATA: begin
          if (accept) begin
            byte_cnt                    <= byte_cnt + 2'd1;
            instruction_initialize_data <= {instruction_initialize_data[23:0], in_data};
`ifdef LOADER_CHECKSUM_EN
            csum                        <= csum_update(csum, in_data);
`endif
          end
        end
        WRITE: begin
          instruction_initialize_address <= instruction_initialize_address + 32'd4;
          count                          <= count - 16'd1;
        end
        default: begin
          byte_cnt <= byte_cnt;
        end
      endcase
    end
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_write <= 1'b0;
      initialize        <= 1'b1;
      cpu_rst           <= 1'b1;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      instruction_write <= (next_state == WRITE);
      initialize        <= (next_state != DONE);
      cpu_rst           <= (next_state != DONE);
      done              <= (next_state == DONE);
      error             <= (next_state == ERROR);
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued by stimulus, a monitor pops them.
module tb_instruction_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        initialize;
  logic [31:0] instruction_initialize_address;
  logic [31:0] instruction_initialize_data;
  logic        instruction_write;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int          checks;
  int          errors;
  logic [7:0]  tb_xor;
  logic [63:0] exp_q[$];

  instruction_loader dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .in_valid                       (in_valid),
    .in_data                        (in_data),
    .in_ready                       (in_ready),
    .initialize                     (initialize),
    .instruction_initialize_address (instruction_initialize_address),
    .instruction_initialize_data    (instruction_initialize_data),
    .instruction_write              (instruction_write),
    .cpu_rst                        (cpu_rst),
    .done                           (done),
    .error                          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tb_xor = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    if (pulse) start = 1'b1;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 required in_ready=1 byte=%h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    tb_xor   = tb_xor ^ b;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap, 1'b0);
  endtask

  task automatic finish_ok(input string name);
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_xor, 0, 1'b0);
`else
    @(posedge clk);
    #1;
`endif
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_init"}, {31'd0, initialize}, 32'd0);
    chk({name, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
  endtask

  initial begin
    logic [7:0] s1 [10];
    logic [63:0] e;
    s1 = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h08, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78};
    checks   = 0;
    errors   = 0;
    tb_xor   = 8'h00;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    chk("rst_init",  {31'd0, initialize}, 32'd1);
    chk("rst_cpu",   {31'd0, cpu_rst}, 32'd1);
    chk("rst_addr",  instruction_initialize_address, 32'd0);
    chk("rst_data",  instruction_initialize_data, 32'd0);
    chk("rst_write", {31'd0, instruction_write}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fork
      begin
        forever begin
          @(negedge clk);
          if (instruction_write) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write got addr=%h data=%h required none",
                       instruction_initialize_address, instruction_initialize_data);
            end else begin
              e = exp_q.pop_front();
              if ({instruction_initialize_address, instruction_initialize_data} !== e) begin
                errors++;
                $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                         instruction_initialize_address, instruction_initialize_data,
                         e[63:32], e[31:0]);
              end
            end
          end
        end
      end
      begin
        // Two-word program, back to back
        exp_q.push_back({32'd0, 32'h0002_0820});
        exp_q.push_back({32'd4, 32'h1234_5678});
        do_start();
        chk("hdr_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 10; i++) send_byte(s1[i], 0, 1'b0);
        chk("last_strobe", {31'd0, instruction_write}, 32'd1);
        chk("write_ready", {31'd0, in_ready}, 32'd0);
        chk("early_done",  {31'd0, done}, 32'd0);
        finish_ok("t1");
        chk("t1_error", {31'd0, error}, 32'd0);

        // Same stream, sparse in_valid and start pulses mid-load
        exp_q.push_back({32'd0, 32'h0002_0820});
        exp_q.push_back({32'd4, 32'h1234_5678});
        do_start();
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_cpu",  {31'd0, cpu_rst}, 32'd1);
        for (int i = 0; i < 10; i++) send_byte(s1[i], 2, (i == 3) || (i == 6) || (i == 9));
        finish_ok("t2");

        // Zero-length program
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_xor, 0, 1'b0);
`endif
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_init", {31'd0, initialize}, 32'd0);

        // Count overflow, then recovery
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        chk("ovf_error", {31'd0, error}, 32'd1);
        chk("ovf_cpu",   {31'd0, cpu_rst}, 32'd1);
        chk("ovf_init",  {31'd0, initialize}, 32'd1);
        chk("ovf_done",  {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("ovf_ready", {31'd0, in_ready}, 32'd0);
        exp_q.push_back({32'd0, 32'hDEAD_BEEF});
        do_start();
        chk("ovf_clear", {31'd0, error}, 32'd0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_word(32'hDEAD_BEEF, 0);
        finish_ok("t4");

        // Reset after two data bytes, then a clean one-word load
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_init",  {31'd0, initialize}, 32'd1);
        chk("mid_cpu",   {31'd0, cpu_rst}, 32'd1);
        chk("mid_addr",  instruction_initialize_address, 32'd0);
        chk("mid_data",  instruction_initialize_data, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_write", {31'd0, instruction_write}, 32'd0);
        chk("mid_done",  {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back({32'd0, 32'hCAFE_BABE});
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_word(32'hCAFE_BABE, 0);
        finish_ok("t5");

`ifdef LOADER_CHECKSUM_EN
        exp_q.push_back({32'd0, 32'hAABB_CCDD});
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'h01, 0, 1'b0);
        chk("csum_ok_done", {31'd0, done}, 32'd1);
        exp_q.push_back({32'd0, 32'hAABB_CCDD});
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'h00, 0, 1'b0);
        chk("csum_bad_error", {31'd0, error}, 32'd1);
        chk("csum_bad_cpu",   {31'd0, cpu_rst}, 32'd1);
`endif
        repeat (4) @(negedge clk);
      end
    join_any
    disable fork;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-stream program loader sitting directly upstream of the single-cycle `cpu`. It receives a length-prefixed program over a valid/ready byte interface and assembles big-endian 32-bit words. Each word is written into the CPU instruction memory through the `initialize` / `instruction_initialize_address` / `instruction_initialize_data` port group. The CPU is held in reset until the load completes, then released.

## Interface
- `BASE_ADDR`, default 0: byte address of the first instruction word.
- `MAX_WORDS`, default 256: instruction memory depth in words; larger header counts are rejected.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge where `in_valid && in_ready`.
- `initialize`  out  1  high while the instruction memory is owned by the loader.
- `instruction_initialize_address`  out  32  write byte address.
- `instruction_initialize_data`  out  32  write data.
- `instruction_write`  out  1  one-cycle write strobe.
- `cpu_rst`  out  1  reset to the CPU.
- `done`  out  1  load completed successfully (level).
- `error`  out  1  load aborted (level).

## Operation
- States:
  - IDLE
  - HDR: 2 bytes, word count, MSB first.
  - DATA: 4 bytes per word, MSB first.
  - WRITE
  - CSUM: only with the macro.
  - DONE
  - ERROR
- Reset values:
  - `initialize`=1, `cpu_rst`=1.
  - Address=`BASE_ADDR`, data=0.
  - `instruction_write`=0, `in_ready`=0, `done`=0, `error`=0.
  - State IDLE.
- IDLE: on `start`, go to HDR.
- HDR:
  - After the 2nd byte, count==0 goes to CSUM (macro) or DONE.
  - After the 2nd byte, count>`MAX_WORDS` goes to ERROR.
  - Otherwise go to DATA.
- DATA: bytes shift into the data register (`data <= {data[23:0], in_data}`). After the 4th byte, go to WRITE.
- WRITE:
  - `instruction_write`=1 for exactly one cycle; address/data are stable and `in_ready`=0.
  - On exit, address += 4 and the remaining count decrements.
  - Next state is DATA, or CSUM/DONE after the last word.
- DONE:
  - `initialize`=0, `cpu_rst`=0, `done`=1, all registered on entry.
  - `start` restarts: on that edge, `initialize`=1, `cpu_rst`=1, `done`=0, address=`BASE_ADDR`, state goes to HDR.
- ERROR:
  - `error`=1, `cpu_rst`=1, `initialize`=1, no further writes.
  - `start` restarts exactly as from DONE and clears `error`.
- `start` in HDR/DATA/WRITE/CSUM is ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32; it is never reached in practice because of the `MAX_WORDS` check.

## Timing
- `in_ready` is combinational from state only: it is 1 exactly in HDR, DATA and CSUM. It never depends on `in_valid`.
- Word latency: 4th byte accepted at edge N, strobe high during cycle N→N+1, next byte acceptable from edge N+2.
- Minimum cost: 5 cycles per word with `in_valid` held high.
- Completion without the macro: last strobe at cycle N→N+1, DONE entered at edge N+1. `cpu_rst` falls on the same edge.
- `rst` mid-load: all outputs take their reset values immediately (asynchronously). Partially assembled words are discarded and no strobe is emitted.
- A `start` pulse coincident with `rst` deassertion edge is ignored.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the last word (or a zero count), CSUM accepts one byte.
  - DONE if the byte equals the XOR of all preceding header and data bytes; otherwise ERROR.
  - The check occurs on the acceptance edge.
- Not defined: no CSUM state; the loader goes directly from the final WRITE or the zero-count header to DONE. `error` is raised only by count overflow.

## Test plan
- Reset, `start`, stream `00 02 00 02 08 20 12 34 56 78`:
  - Strobes at addr 0 data 0x00020820, then addr 4 data 0x12345678.
  - `done`=1, `initialize`=0 and `cpu_rst`=0 one cycle after the 2nd strobe.
- Same stream with `in_valid` high every 3rd cycle and random `start` pulses mid-load: identical writes, no duplicated or lost bytes, `start` ignored.
- Header `00 00`: no strobes; DONE 1 cycle after the 2nd header byte (macro off).
- Header count `MAX_WORDS+1` (0x0101): `error`=1, no strobe, `cpu_rst` stays 1. A subsequent `start` followed by a valid stream yields DONE.
- Assert `rst` after 2 data bytes: outputs reset immediately. Then `start` plus a 1-word stream gives a single strobe at `BASE_ADDR` with the correct data.
- With `LOADER_CHECKSUM_EN`: stream `00 01 AA BB CC DD` + correct checksum 0x01 → DONE. The same stream with checksum 0x00 → ERROR, `cpu_rst`=1.
